// File: rtl/fft_frame_collector.sv
// fft_frame_collector
// Collects NCH serial complex FFT bins (bin index on s_tuser) into one
// parallel frame. Each component is sign-extended, gain-shifted and clamped
// as it arrives. Out-of-order bins drop the partial frame and force a resync
// on bin 0. A one-deep output slot with m_tvalid/m_tready back-pressures the
// input through the FULL state.
module fft_frame_collector #(
  parameter int NCH     = 8,
  parameter int IN_W    = 16,
  parameter int OUT_W   = 20,
  parameter int GAIN_SH = 0,
  parameter int BIT_REV = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*IN_W-1:0]      s_tdata,
  input  logic [$clog2(NCH)-1:0] s_tuser,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [NCH*OUT_W-1:0]   m_real,
  output logic [NCH*OUT_W-1:0]   m_imag,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_sat,
  output logic                   frame_err,
  output logic [15:0]            frame_cnt,
  output logic [7:0]             err_cnt
);

  localparam int LOG   = $clog2(NCH);
  // Wide enough that the shift never loses bits before the range check.
  localparam int EXT_W = OUT_W + GAIN_SH;

  typedef enum logic [1:0] {SYNC, COLLECT, FULL} state_t;

  state_t           state_reg, state_next;
  logic [LOG-1:0]   k_reg, k_next;
  logic             store;
  logic             transfer;
  logic             err_set;
  logic             accept;
  logic             slot_free;

  logic [OUT_W:0]   conv_re;
  logic [OUT_W:0]   conv_im;
  logic             in_sat;

  logic [OUT_W-1:0] buf_re_reg  [NCH];
  logic [OUT_W-1:0] buf_im_reg  [NCH];
  logic             buf_sat_reg [NCH];
  logic [OUT_W-1:0] out_re_reg  [NCH];
  logic [OUT_W-1:0] out_im_reg  [NCH];
  logic [OUT_W-1:0] lane_re     [NCH];
  logic [OUT_W-1:0] lane_im     [NCH];
  logic [NCH-1:0]   lane_sat;

  // Index expected at frame position pos (optionally bit-reversed).
  function automatic logic [LOG-1:0] expected_idx(input logic [LOG-1:0] pos);
    logic [LOG-1:0] r;
    r = pos;
    if (BIT_REV != 0) begin
      for (int b = 0; b < LOG; b++) begin
        r[b] = pos[LOG-1-b];
      end
    end
    return r;
  endfunction

  // Returns {saturated, value}: sign-extend, shift, clamp to signed OUT_W.
  function automatic logic [OUT_W:0] convert(input logic [IN_W-1:0] x);
    logic signed [EXT_W-1:0] ext;
    logic [EXT_W-OUT_W:0]    top;
    ext = EXT_W'($signed(x));
    ext = ext <<< GAIN_SH;
    top = ext[EXT_W-1:OUT_W-1];
    if ((&top) || !(|top)) begin
      return {1'b0, ext[OUT_W-1:0]};
    end else if (ext[EXT_W-1]) begin
      return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    end
  endfunction

  assign conv_re   = convert(s_tdata[IN_W-1:0]);
  assign conv_im   = convert(s_tdata[2*IN_W-1:IN_W]);
  assign in_sat    = conv_re[OUT_W] | conv_im[OUT_W];
  assign accept    = s_tvalid && s_tready;
  assign slot_free = !m_tvalid || m_tready;

  // State register and position counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= SYNC;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
    end
  end

  // Next-state decode: sequence tracking, storing, transfer and error detection.
  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    store      = 1'b0;
    transfer   = 1'b0;
    err_set    = 1'b0;
    s_tready   = (state_reg != FULL);
    case (state_reg)
      SYNC: begin
        if (accept && (s_tuser == expected_idx(LOG'(0)))) begin
          store      = 1'b1;
          state_next = COLLECT;
          k_next     = LOG'(1);
        end
      end
      COLLECT: begin
        if (accept) begin
          if (s_tuser == expected_idx(k_reg)) begin
            store = 1'b1;
            if (k_reg == LOG'(NCH-1)) begin
              k_next = '0;
              if (slot_free) begin
                transfer = 1'b1;
              end else begin
                state_next = FULL;
              end
            end else begin
              k_next = k_reg + 1'b1;
            end
          end else begin
            err_set = 1'b1;
            if (s_tuser == expected_idx(LOG'(0))) begin
              store  = 1'b1;
              k_next = LOG'(1);
            end else begin
              state_next = SYNC;
              k_next     = '0;
            end
          end
        end
      end
      FULL: begin
        if (slot_free) begin
          transfer   = 1'b1;
          state_next = COLLECT;
          k_next     = '0;
        end
      end
      default: begin
        state_next = SYNC;
        k_next     = '0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_lane
      logic hit;
      assign hit          = store && (s_tuser == LOG'(gi));
      // Lane contents including a bin written this cycle, so the last bin
      // can transfer straight to the output slot.
      assign lane_re[gi]  = hit ? conv_re[OUT_W-1:0] : buf_re_reg[gi];
      assign lane_im[gi]  = hit ? conv_im[OUT_W-1:0] : buf_im_reg[gi];
      assign lane_sat[gi] = hit ? in_sat : buf_sat_reg[gi];
      assign m_real[gi*OUT_W +: OUT_W] = out_re_reg[gi];
      assign m_imag[gi*OUT_W +: OUT_W] = out_im_reg[gi];

      // Collect buffer lane: written when its bin is stored.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          buf_re_reg[gi]  <= '0;
          buf_im_reg[gi]  <= '0;
          buf_sat_reg[gi] <= 1'b0;
        end else if (hit) begin
          buf_re_reg[gi]  <= conv_re[OUT_W-1:0];
          buf_im_reg[gi]  <= conv_im[OUT_W-1:0];
          buf_sat_reg[gi] <= in_sat;
        end
      end

      // Output lane: loads on transfer, holds otherwise.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_re_reg[gi] <= '0;
          out_im_reg[gi] <= '0;
        end else if (transfer) begin
          out_re_reg[gi] <= lane_re[gi];
          out_im_reg[gi] <= lane_im[gi];
        end
      end
    end
  endgenerate

  // Output handshake, frame-level saturation flag, error pulse and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tvalid  <= 1'b0;
      m_sat     <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      frame_err <= err_set;
      if (transfer) begin
        m_tvalid  <= 1'b1;
        m_sat     <= |lane_sat;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
      if (err_set && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_collector.sv
// Bench for fft_frame_collector: three instances (natural/gain 0,
// bit-reversed/gain 5, bit-reversed/gain 4) against a frame-level reference.
module tb_fft_frame_collector;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_tdata  [2];
  logic [2:0]  s_tuser  [2];
  logic        s_tvalid [2];
  logic        m_tready [2];

  logic         tr   [NI];
  logic [159:0] mr   [NI];
  logic [159:0] mi   [NI];
  logic         mv   [NI];
  logic         msat [NI];
  logic         ferr [NI];
  logic [15:0]  fc   [NI];
  logic [7:0]   ec   [NI];

  always #5 clk = ~clk;

  fft_frame_collector #(.NCH(8), .IN_W(16), .OUT_W(20), .GAIN_SH(0), .BIT_REV(0)) dut0 (
    .clk(clk), .rst(rst), .s_tdata(s_tdata[0]), .s_tuser(s_tuser[0]), .s_tvalid(s_tvalid[0]),
    .s_tready(tr[0]), .m_real(mr[0]), .m_imag(mi[0]), .m_tvalid(mv[0]), .m_tready(m_tready[0]),
    .m_sat(msat[0]), .frame_err(ferr[0]), .frame_cnt(fc[0]), .err_cnt(ec[0]));

  fft_frame_collector #(.NCH(8), .IN_W(16), .OUT_W(20), .GAIN_SH(5), .BIT_REV(1)) dut1 (
    .clk(clk), .rst(rst), .s_tdata(s_tdata[1]), .s_tuser(s_tuser[1]), .s_tvalid(s_tvalid[1]),
    .s_tready(tr[1]), .m_real(mr[1]), .m_imag(mi[1]), .m_tvalid(mv[1]), .m_tready(m_tready[1]),
    .m_sat(msat[1]), .frame_err(ferr[1]), .frame_cnt(fc[1]), .err_cnt(ec[1]));

  fft_frame_collector #(.NCH(8), .IN_W(16), .OUT_W(20), .GAIN_SH(4), .BIT_REV(1)) dut2 (
    .clk(clk), .rst(rst), .s_tdata(s_tdata[1]), .s_tuser(s_tuser[1]), .s_tvalid(s_tvalid[1]),
    .s_tready(tr[2]), .m_real(mr[2]), .m_imag(mi[2]), .m_tvalid(mv[2]), .m_tready(m_tready[1]),
    .m_sat(msat[2]), .frame_err(ferr[2]), .frame_cnt(fc[2]), .err_cnt(ec[2]));

  // Reference model state per instance.
  int  coll_re [NI][8];
  int  coll_im [NI][8];
  bit  coll_sat[NI][8];
  int  out_re  [NI][8];
  int  out_im  [NI][8];
  bit  out_sat [NI];
  bit  o_valid [NI];
  bit  full    [NI];
  bit  synced  [NI];
  bit  err_pulse[NI];
  int  k       [NI];
  int  frames  [NI];
  int  errs    [NI];

  int n_tests;
  int n_fail;

  function automatic int gain_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 5 : 4);
  endfunction

  function automatic bit rev_of(input int i);
    return (i != 0);
  endfunction

  function automatic int grp_of(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  function automatic int bitrev3(input int v);
    return ((v & 1) << 2) | (v & 2) | ((v >> 2) & 1);
  endfunction

  // Ideal gain then clamp to the signed 20-bit range.
  function automatic int conv(input logic [15:0] x, input int sh, output bit sat);
    int v;
    v   = int'($signed(x)) * (1 << sh);
    sat = 1'b0;
    if (v > 524287) begin
      v = 524287;  sat = 1'b1;
    end else if (v < -524288) begin
      v = -524288; sat = 1'b1;
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int l = 0; l < 8; l++) begin
        coll_re[i][l] = 0; coll_im[i][l] = 0; coll_sat[i][l] = 1'b0;
        out_re[i][l]  = 0; out_im[i][l]  = 0;
      end
      out_sat[i] = 1'b0; o_valid[i] = 1'b0; full[i] = 1'b0; synced[i] = 1'b0;
      err_pulse[i] = 1'b0; k[i] = 0; frames[i] = 0; errs[i] = 0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      logic [159:0] er;
      logic [159:0] ei;
      er = '0;
      ei = '0;
      for (int l = 0; l < 8; l++) begin
        er[l*20 +: 20] = out_re[i][l][19:0];
        ei[l*20 +: 20] = out_im[i][l][19:0];
      end
      check($sformatf("dut%0d.tready", i), 160'(tr[i]), 160'(full[i] ? 1'b0 : 1'b1));
      check($sformatf("dut%0d.tvalid", i), 160'(mv[i]), 160'(o_valid[i]));
      check($sformatf("dut%0d.frame_err", i), 160'(ferr[i]), 160'(err_pulse[i]));
      check($sformatf("dut%0d.frame_cnt", i), 160'(fc[i]), 160'(frames[i]));
      check($sformatf("dut%0d.err_cnt", i), 160'(ec[i]), 160'(errs[i]));
      check($sformatf("dut%0d.sat", i), 160'(msat[i]), 160'(out_sat[i]));
      check($sformatf("dut%0d.real", i), mr[i], er);
      check($sformatf("dut%0d.imag", i), mi[i], ei);
    end
  endtask

  // Apply the current inputs to the model, clock once, then compare.
  task automatic tick();
    for (int i = 0; i < NI; i++) begin
      int g, u, eu;
      bit sr, si, sf, xfer, store;
      g = grp_of(i);
      sf = !o_valid[i] || m_tready[g];
      xfer = 1'b0;
      store = 1'b0;
      u = int'(s_tuser[g]);
      err_pulse[i] = 1'b0;
      if (full[i]) begin
        if (sf) begin
          xfer = 1'b1;
          full[i] = 1'b0;
        end
      end else if (s_tvalid[g]) begin
        eu = rev_of(i) ? bitrev3(k[i]) : k[i];
        if (!synced[i]) begin
          if (u == 0) begin
            store = 1'b1; synced[i] = 1'b1; k[i] = 1;
          end
        end else if (u == eu) begin
          store = 1'b1;
          if (k[i] == 7) begin
            k[i] = 0;
            if (sf) xfer = 1'b1;
            else    full[i] = 1'b1;
          end else begin
            k[i]++;
          end
        end else begin
          err_pulse[i] = 1'b1;
          if (errs[i] < 255) errs[i]++;
          if (u == 0) begin
            store = 1'b1; k[i] = 1;
          end else begin
            synced[i] = 1'b0; k[i] = 0;
          end
        end
        if (store) begin
          coll_re[i][u]  = conv(s_tdata[g][15:0], gain_of(i), sr);
          coll_im[i][u]  = conv(s_tdata[g][31:16], gain_of(i), si);
          coll_sat[i][u] = sr | si;
        end
      end
      if (xfer) begin
        out_sat[i] = 1'b0;
        for (int l = 0; l < 8; l++) begin
          out_re[i][l] = coll_re[i][l];
          out_im[i][l] = coll_im[i][l];
          out_sat[i]   = out_sat[i] | coll_sat[i][l];
        end
        o_valid[i] = 1'b1;
        frames[i]  = (frames[i] + 1) % 65536;
        $display("[TB] t=%0t dut%0d frame %0d delivered sat=%0b", $time, i, frames[i], out_sat[i]);
      end else if (m_tready[g]) begin
        o_valid[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input int g, input bit v, input int u, input int re, input int im);
    s_tvalid[g] = v;
    s_tuser[g]  = 3'(u);
    s_tdata[g]  = {16'(im), 16'(re)};
  endtask

  task automatic apply_reset();
    drive(0, 1'b0, 0, 0, 0);
    drive(1, 1'b0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clean_frame(input int g);
    for (int b = 0; b < 8; b++) begin
      drive(g, 1'b1, (g == 1) ? bitrev3(b) : b, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      tick();
    end
    drive(g, 1'b0, 0, 0, 0);
  endtask

  initial begin
    logic [159:0] xr;
    logic [159:0] xi;
    logic [159:0] xr2;
    int gen_pos[2];
    n_tests = 0;
    n_fail  = 0;
    m_tready[0] = 1'b1;
    m_tready[1] = 1'b1;
    apply_reset();

    // Natural order frame, real=i+1, imag=-(i+1).
    for (int b = 0; b < 8; b++) begin
      drive(0, 1'b1, b, b + 1, -(b + 1));
      tick();
    end
    drive(0, 1'b0, 0, 0, 0);
    for (int l = 0; l < 8; l++) begin
      xr[l*20 +: 20] = 20'(l + 1);
      xi[l*20 +: 20] = 20'(-(l + 1));
    end
    check("nat.real", mr[0], xr);
    check("nat.imag", mi[0], xi);
    check("nat.tvalid", 160'(mv[0]), 160'(1));
    check("nat.frame_cnt", 160'(fc[0]), 160'(1));
    check("nat.sat", 160'(msat[0]), 160'(0));
    tick();

    // Bit-reversed arrival, real = tuser.
    for (int b = 0; b < 8; b++) begin
      drive(1, 1'b1, bitrev3(b), bitrev3(b), 0);
      tick();
    end
    drive(1, 1'b0, 0, 0, 0);
    for (int l = 0; l < 8; l++) begin
      xr[l*20 +: 20]  = 20'(l * 32);
      xr2[l*20 +: 20] = 20'(l * 16);
    end
    check("rev.real_g5", mr[1], xr);
    check("rev.real_g4", mr[2], xr2);
    check("rev.err_cnt", 160'(ec[1]), 160'(0));
    tick();

    // Saturation: real=0x7FFF, imag=0x8000.
    for (int b = 0; b < 8; b++) begin
      drive(1, 1'b1, bitrev3(b), 'h7FFF, 'h8000);
      tick();
    end
    drive(1, 1'b0, 0, 0, 0);
    check("sat.g5_real", 160'(mr[1][19:0]), 160'(20'd524287));
    check("sat.g5_imag", 160'(mi[1][19:0]), 160'(20'h80000));
    check("sat.g5_flag", 160'(msat[1]), 160'(1));
    check("sat.g4_real", 160'(mr[2][19:0]), 160'(20'd524272));
    check("sat.g4_imag", 160'(mi[2][19:0]), 160'(20'h80000));
    check("sat.g4_flag", 160'(msat[2]), 160'(0));
    tick();

    // Sequence error: 0,1,2,5 then 3,4 (discarded), then a clean frame.
    for (int b = 0; b < 6; b++) begin
      int seq;
      seq = (b < 3) ? b : ((b == 3) ? 5 : b - 1);
      drive(0, 1'b1, seq, 100 + b, 200 + b);
      tick();
      if (b == 3) begin
        check("seq.frame_err", 160'(ferr[0]), 160'(1));
        check("seq.err_cnt", 160'(ec[0]), 160'(1));
      end
    end
    drive(0, 1'b0, 0, 0, 0);
    tick();
    clean_frame(0);
    check("seq.frame_cnt", 160'(fc[0]), 160'(2));
    tick();

    // Back-pressure: two frames with m_tready low, then a one-cycle release.
    m_tready[0] = 1'b0;
    clean_frame(0);
    clean_frame(0);
    check("bp.tready_low", 160'(tr[0]), 160'(0));
    check("bp.frame_cnt_held", 160'(fc[0]), 160'(3));
    tick();
    tick();
    m_tready[0] = 1'b1;
    tick();
    check("bp.tready_high", 160'(tr[0]), 160'(1));
    check("bp.frame_cnt", 160'(fc[0]), 160'(4));
    check("bp.tvalid", 160'(mv[0]), 160'(1));
    tick();

    // Reset mid-frame, then a clean frame.
    for (int b = 0; b < 3; b++) begin
      drive(0, 1'b1, b, b, b);
      tick();
    end
    #2;
    apply_reset();
    clean_frame(0);
    check("rst.frame_cnt", 160'(fc[0]), 160'(1));
    tick();

    // Randomized traffic with random back-pressure and occasional bad indices.
    gen_pos[0] = 0;
    gen_pos[1] = 0;
    for (int c = 0; c < 1200; c++) begin
      for (int g = 0; g < 2; g++) begin
        bit v, bad;
        int u, re, im;
        m_tready[g] = ($urandom_range(0, 9) < 8);
        v   = ($urandom_range(0, 9) < 9);
        bad = ($urandom_range(0, 19) == 0);
        u   = (g == 1) ? bitrev3(gen_pos[g]) : gen_pos[g];
        if (bad) u = int'($urandom_range(0, 7));
        re = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 16383)) - 8192 : int'($urandom_range(0, 65535));
        im = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 16383)) - 8192 : int'($urandom_range(0, 65535));
        drive(g, v, u, re, im);
        if (v && !full[(g == 0) ? 0 : 1]) begin
          gen_pos[g] = bad ? 0 : (gen_pos[g] + 1) % 8;
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
